// File: rtl/cpu_fetch.sv
// -----------------------------------------------------------------------------
// cpu_fetch
//   Instruction fetch unit for a one-cycle CPU. It holds a 2^AW x WIDTH
//   instruction memory that is filled through a load port, a program counter,
//   a base register for relative jumps, and a four-state control FSM
//   (IDLE / LOAD / RUN / HALT).
//
// Ports
//   CLK             : clock, all state changes on the rising edge
//   RST             : synchronous reset, active-low
//   LOAD_REQ        : request to enter program-load mode
//   LOAD_VALID      : load word valid this cycle
//   LOAD_LAST       : final load word; returns to IDLE after writing it
//   LOAD_ADDR[AW]   : load target address
//   LOAD_DATA[W]    : load instruction word
//   LOAD_READY      : high only in LOAD
//   START           : begin (from IDLE, PC cleared) or resume (from HALT)
//   STOP            : halt execution; wins over decoder strobes
//   SOFT_RST        : decoder RST strobe, clears PC and base register
//   PC_LD           : decoder jump strobe
//   JMP_MODE        : 0 = absolute IMM, 1 = base + BASE_REG_OFFSET
//   IMM[AW]         : absolute jump target
//   BASE_REG_LD     : load base register with BASE_REG_DATA
//   BASE_REG_DATA   : new base value
//   BASE_REG_OFFSET : relative jump offset
//   INSTR[W]        : mem[PC] in RUN, NOP word otherwise
//   PC[AW]          : current program counter
//   RUNNING         : high only in RUN
// -----------------------------------------------------------------------------
module cpu_fetch #(
  parameter int          WIDTH      = 13,
  parameter int          IWIDTH     = 5,
  parameter int unsigned NOP_OPCODE = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      LOAD_REQ,
  input  logic                      LOAD_VALID,
  input  logic                      LOAD_LAST,
  input  logic [WIDTH-IWIDTH-1:0]   LOAD_ADDR,
  input  logic [WIDTH-1:0]          LOAD_DATA,
  output logic                      LOAD_READY,
  input  logic                      START,
  input  logic                      STOP,
  input  logic                      SOFT_RST,
  input  logic                      PC_LD,
  input  logic                      JMP_MODE,
  input  logic [WIDTH-IWIDTH-1:0]   IMM,
  input  logic                      BASE_REG_LD,
  input  logic [WIDTH-IWIDTH-1:0]   BASE_REG_DATA,
  input  logic [WIDTH-IWIDTH-1:0]   BASE_REG_OFFSET,
  output logic [WIDTH-1:0]          INSTR,
  output logic [WIDTH-IWIDTH-1:0]   PC,
  output logic                      RUNNING
);

  localparam int AW    = WIDTH - IWIDTH;
  localparam int DEPTH = 2 ** AW;

  // Word presented to the decoder whenever the CPU is not running.
  localparam logic [IWIDTH-1:0] NOP_OP   = IWIDTH'(NOP_OPCODE);
  localparam logic [WIDTH-1:0]  NOP_WORD = {NOP_OP, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   base_q, base_d;
  logic            mem_we_s;
  logic [AW-1:0]   rel_target_s;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Relative jump target always uses the current (old) base; carry dropped.
  assign rel_target_s = base_q + BASE_REG_OFFSET;

  // Next-state, PC, base register and memory write-enable decode.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    base_d   = base_q;
    mem_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (LOAD_REQ) begin
          state_d = S_LOAD;
        end else if (START) begin
          state_d = S_RUN;
          pc_d    = {AW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (LOAD_VALID) begin
          // A reset edge aborts the load without writing.
          mem_we_s = RST;
          if (LOAD_LAST) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (STOP) begin
          // Halting edge freezes PC and base; decoder strobes are dropped.
          state_d = S_HALT;
        end else begin
          state_d = S_RUN;
          if (SOFT_RST) begin
            pc_d = {AW{1'b0}};
          end else if (PC_LD && !JMP_MODE) begin
            pc_d = IMM;
          end else if (PC_LD && JMP_MODE) begin
            pc_d = rel_target_s;
          end else begin
            pc_d = pc_q + AW'(1);
          end
          if (SOFT_RST) begin
            base_d = {AW{1'b0}};
          end else if (BASE_REG_LD) begin
            base_d = BASE_REG_DATA;
          end else begin
            base_d = base_q;
          end
        end
      end
      S_HALT: begin
        if (LOAD_REQ) begin
          state_d = S_LOAD;
        end else if (START) begin
          state_d = S_RUN;
        end else begin
          state_d = S_HALT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state, PC and base register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      pc_q    <= {AW{1'b0}};
      base_q  <= {AW{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      base_q  <= base_d;
    end
  end

  // Instruction memory write port; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_q[LOAD_ADDR] <= LOAD_DATA;
    end
  end

  // Zero-latency fetch: the one-cycle CPU consumes mem[PC] in the same cycle.
  assign INSTR      = (state_q == S_RUN) ? mem_q[pc_q] : NOP_WORD;
  assign PC         = pc_q;
  assign RUNNING    = (state_q == S_RUN);
  assign LOAD_READY = (state_q == S_LOAD);

endmodule
